// File: rtl/meas_point_buf.sv
// Point collector for the two channel measurement controllers: one hold register
// per channel, round-robin on contention, then a first-word-fall-through FIFO.
module meas_point_buf #(
  parameter int DEPTH   = 16,
  parameter int V_WIDTH = 16,
  parameter int T_WIDTH = 10,
  localparam int W      = 1 + T_WIDTH + V_WIDTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               clr_i,
  input  logic               p1_rdy_i,
  input  logic [V_WIDTH-1:0] p1_v_i,
  input  logic [T_WIDTH-1:0] p1_t_i,
  input  logic               p2_rdy_i,
  input  logic [V_WIDTH-1:0] p2_v_i,
  input  logic [T_WIDTH-1:0] p2_t_i,
  input  logic               rd_i,
  output logic [W-1:0]       rd_data_o,
  output logic               rd_valid_o,
  output logic [AW:0]        level_o,
  output logic               ovf_o,
  output logic [7:0]         drop_cnt_o
);

  typedef enum logic {
    CH1 = 1'b0,
    CH2 = 1'b1
  } ch_e;

  typedef struct packed {
    logic               full;
    logic [T_WIDTH-1:0] t;
    logic [V_WIDTH-1:0] v;
  } hold_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  hold_t          h1_q, h1_d, h2_q, h2_d;
  ch_e            last_grant_q, last_grant_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic [W-1:0]   mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    level_q, level_d;
  logic           ovf_q, ovf_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;

  logic           rd_valid, pop, can_wr, wr_en, grant2;
  logic           drain1, drain2, load1, load2, drop1, drop2;
  logic [W-1:0]   wdata;
  logic [8:0]     drop_sum;

  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    h1_d         = h1_q;
    h2_d         = h2_q;
    last_grant_d = last_grant_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    ovf_d        = ovf_q;
    drop_cnt_d   = drop_cnt_q;

    rd_valid = (level_q != '0);
    pop      = rd_i && rd_valid;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    can_wr   = (level_q != DEPTH_L) || pop;

    if (h1_q.full && h2_q.full) grant2 = (last_grant_q == CH1);
    else                        grant2 = h2_q.full;

    wr_en  = can_wr && (h1_q.full || h2_q.full);
    wdata  = grant2 ? {1'b1, h2_q.t, h2_q.v} : {1'b0, h1_q.t, h1_q.v};
    drain1 = wr_en && !grant2;
    drain2 = wr_en && grant2;

    if (wr_en && h1_q.full && h2_q.full) last_grant_d = grant2 ? CH2 : CH1;

    load1 = p1_rdy_i && (!h1_q.full || drain1);
    load2 = p2_rdy_i && (!h2_q.full || drain2);
    drop1 = p1_rdy_i && !load1;
    drop2 = p2_rdy_i && !load2;

    if (load1)       h1_d = '{full: 1'b1, t: p1_t_i, v: p1_v_i};
    else if (drain1) h1_d.full = 1'b0;
    if (load2)       h2_d = '{full: 1'b1, t: p2_t_i, v: p2_v_i};
    else if (drain2) h2_d.full = 1'b0;

    ovf_d    = ovf_q || drop1 || drop2;
    drop_sum = {1'b0, drop_cnt_q} + 9'(drop1) + 9'(drop2);
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    if (wr_en) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Clear overrides every update above, including strobes and pops this cycle.
    if (clr_i) begin
      h1_d         = '0;
      h2_d         = '0;
      last_grant_d = CH2;
      mem_d        = '{default: '0};
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      ovf_d        = 1'b0;
      drop_cnt_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of process ordering.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      h1_q         <= '0;
      h2_q         <= '0;
      last_grant_q <= CH2;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ovf_q        <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      h1_q         <= h1_d;
      h2_q         <= h2_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ovf_q        <= ovf_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // NOTE: the storage array is reset deliberately so the head output reads
  // zero out of reset; it is small enough to live in flops.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign rd_valid_o = rd_valid;
  assign level_o    = level_q;
  assign ovf_o      = ovf_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_meas_point_buf.sv
// Scoreboard bench for meas_point_buf: stimulus pushes expected words, a negedge
// monitor pops and compares each word the DUT hands out on a read.
module tb_meas_point_buf;

  localparam int DEPTH = 16;
  localparam int VW    = 16;
  localparam int TW    = 10;
  localparam int W     = 1 + TW + VW;

  logic          clk_i = 1'b0;
  logic          arst_i, clr_i, rd_i;
  logic          p1_rdy_i, p2_rdy_i;
  logic [VW-1:0] p1_v_i, p2_v_i;
  logic [TW-1:0] p1_t_i, p2_t_i;
  logic [W-1:0]  rd_data_o;
  logic          rd_valid_o, ovf_o;
  logic [4:0]    level_o;
  logic [7:0]    drop_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] sb [$];

  meas_point_buf #(.DEPTH(DEPTH), .V_WIDTH(VW), .T_WIDTH(TW)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .clr_i(clr_i),
    .p1_rdy_i(p1_rdy_i), .p1_v_i(p1_v_i), .p1_t_i(p1_t_i),
    .p2_rdy_i(p2_rdy_i), .p2_v_i(p2_v_i), .p2_t_i(p2_t_i),
    .rd_i(rd_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .level_o(level_o), .ovf_o(ovf_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic ch, input logic [TW-1:0] t, input logic [VW-1:0] v);
    return {ch, t, v};
  endfunction

  // Monitor: a read is accepted at the coming edge whenever rd_i meets rd_valid_o.
  always @(negedge clk_i) begin
    if (!arst_i && !clr_i && rd_i && rd_valid_o) begin
      if (sb.size() == 0) check("unexpected_word", 32'(rd_data_o), 32'hDEAD_BEEF);
      else                check("rd_data", 32'(rd_data_o), 32'(sb.pop_front()));
    end
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drain();
    int n = 0;
    rd_i = 1'b1;
    while (rd_valid_o && n < 64) begin
      tick();
      n++;
    end
    rd_i = 1'b0;
    check("drain_done", 32'(rd_valid_o), 32'd0);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic single_point();
    p1_rdy_i = 1'b1; p1_v_i = 16'h1234; p1_t_i = 10'h05;
    sb.push_back(mk(1'b0, 10'h05, 16'h1234));
    tick();
    p1_rdy_i = 1'b0;
    tick();
    check("sp_valid", 32'(rd_valid_o), 32'd1);
    check("sp_data", 32'(rd_data_o), 32'(mk(1'b0, 10'h05, 16'h1234)));
    check("sp_level", 32'(level_o), 32'd1);
    rd_i = 1'b1;
    tick();
    rd_i = 1'b0;
    check("sp_level_after_pop", 32'(level_o), 32'd0);
    check("sp_valid_after_pop", 32'(rd_valid_o), 32'd0);
  endtask

  task automatic pair_alternation();
    p1_rdy_i = 1'b1; p1_v_i = 16'd1; p1_t_i = 10'd1;
    p2_rdy_i = 1'b1; p2_v_i = 16'd2; p2_t_i = 10'd2;
    sb.push_back(mk(1'b0, 10'd1, 16'd1));
    sb.push_back(mk(1'b1, 10'd2, 16'd2));
    tick();
    p1_rdy_i = 1'b0; p2_rdy_i = 1'b0;
    idle(3);
    p1_rdy_i = 1'b1; p1_v_i = 16'd3; p1_t_i = 10'd3;
    p2_rdy_i = 1'b1; p2_v_i = 16'd4; p2_t_i = 10'd4;
    sb.push_back(mk(1'b1, 10'd4, 16'd4));
    sb.push_back(mk(1'b0, 10'd3, 16'd3));
    tick();
    p1_rdy_i = 1'b0; p2_rdy_i = 1'b0;
    idle(3);
    check("pair_level", 32'(level_o), 32'd4);
    drain();
    check("pair_no_drops", 32'(drop_cnt_o), 32'd0);
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    sb.delete();
  endtask

  initial begin
    arst_i = 1'b1; clr_i = 1'b0; rd_i = 1'b0;
    p1_rdy_i = 1'b0; p1_v_i = '0; p1_t_i = '0;
    p2_rdy_i = 1'b0; p2_v_i = '0; p2_t_i = '0;
    idle(2);
    check("rst_valid", 32'(rd_valid_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_data", 32'(rd_data_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_drop", 32'(drop_cnt_o), 32'd0);
    arst_i = 1'b0;
    tick();

    // Read while empty is ignored.
    rd_i = 1'b1;
    tick();
    rd_i = 1'b0;
    check("empty_rd_level", 32'(level_o), 32'd0);
    check("empty_rd_ovf", 32'(ovf_o), 32'd0);

    single_point();
    pair_alternation();

    // Fill: 18 back-to-back channel 1 strobes, 17 stored, 1 dropped.
    for (int k = 0; k < 18; k++) begin
      p1_rdy_i = 1'b1; p1_v_i = 16'h0100 + 16'(k); p1_t_i = 10'(k);
      if (k < 17) sb.push_back(mk(1'b0, 10'(k), 16'h0100 + 16'(k)));
      tick();
    end
    p1_rdy_i = 1'b0;
    check("fill_level", 32'(level_o), 32'd16);
    check("fill_valid", 32'(rd_valid_o), 32'd1);
    check("fill_ovf", 32'(ovf_o), 32'd1);
    check("fill_drop", 32'(drop_cnt_o), 32'd1);
    idle(2);
    check("fill_level_stall", 32'(level_o), 32'd16);

    // Pop while full: the held point enters in the same cycle.
    rd_i = 1'b1;
    tick();
    rd_i = 1'b0;
    check("full_rw_level", 32'(level_o), 32'd16);
    drain();
    check("fill_drop_kept", 32'(drop_cnt_o), 32'd1);

    // Saturation: both channels strobing with no reads.
    for (int k = 0; k < 170; k++) begin
      p1_rdy_i = 1'b1; p2_rdy_i = 1'b1;
      tick();
    end
    p1_rdy_i = 1'b0; p2_rdy_i = 1'b0;
    check("sat_drop", 32'(drop_cnt_o), 32'd255);
    check("sat_ovf", 32'(ovf_o), 32'd1);
    check("sat_level", 32'(level_o), 32'd16);

    // Clear with a strobe and a read in the same cycle.
    p1_rdy_i = 1'b1; p1_v_i = 16'hBEEF; p1_t_i = 10'h3FF; rd_i = 1'b1;
    pulse_clr();
    p1_rdy_i = 1'b0; rd_i = 1'b0;
    check("clr_level", 32'(level_o), 32'd0);
    check("clr_valid", 32'(rd_valid_o), 32'd0);
    check("clr_ovf", 32'(ovf_o), 32'd0);
    check("clr_drop", 32'(drop_cnt_o), 32'd0);
    idle(3);
    check("clr_strobe_ignored", 32'(level_o), 32'd0);

    // Both channels dropping in one cycle count as two.
    for (int k = 0; k < 17; k++) begin
      p1_rdy_i = 1'b1; p1_v_i = 16'(k); p1_t_i = 10'(k);
      tick();
    end
    p1_rdy_i = 1'b0;
    p2_rdy_i = 1'b1;
    tick();
    p1_rdy_i = 1'b1;
    tick();
    p1_rdy_i = 1'b0; p2_rdy_i = 1'b0;
    check("dual_drop_cnt", 32'(drop_cnt_o), 32'd2);
    check("dual_drop_ovf", 32'(ovf_o), 32'd1);
    pulse_clr();

    // Asynchronous reset with 5 entries stored.
    for (int k = 0; k < 5; k++) begin
      p1_rdy_i = 1'b1; p1_v_i = 16'hA000 + 16'(k); p1_t_i = 10'(k);
      tick();
    end
    p1_rdy_i = 1'b0;
    idle(2);
    check("ar_level_before", 32'(level_o), 32'd5);
    #2;
    arst_i = 1'b1;
    #1;
    check("ar_level", 32'(level_o), 32'd0);
    check("ar_valid", 32'(rd_valid_o), 32'd0);
    check("ar_data", 32'(rd_data_o), 32'd0);
    check("ar_drop", 32'(drop_cnt_o), 32'd0);
    tick();
    arst_i = 1'b0;
    sb.delete();
    tick();
    single_point();
    pair_alternation();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
